// File: rtl/ysyx_23060072_lsu_pipe.sv
// ysyx_23060072_lsu_pipe
//   Single-outstanding load/store unit. It computes EA = base + offset and
//   issues one NB-aligned bus request with lane-shifted data and byte strobes.
//   It then waits for the response, extends load data, and pulses
//   rsp_valid_o for one cycle. An internal watchdog bounds the time spent in
//   REQ+WAIT.
//   Optional feature: define LSU_MISALIGN_CHK_EN to trap misaligned accesses
//   (no bus request, rsp_misalign_o=1). Without it, the EA is silently
//   aligned down to the access size.
module ysyx_23060072_lsu_pipe #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [ADDR_W-1:0]   req_base_i,
  input  logic [ADDR_W-1:0]   req_offset_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_rsp_valid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_rsp_err_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                rsp_misalign_o,
  output logic                busy_o
);

  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  // Request payload, captured on acceptance only.
  logic [ADDR_W-1:0]   ea_q;
  logic [1:0]          size_q;
  logic                we_q;
  logic                uns_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [ADDR_W-1:0]   ea_raw;
  logic [ADDR_W-1:0]   amask;
  logic                accept;
  logic                tmo;
  logic [LW-1:0]       lane;
  logic [7:0]          smask;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   load_ext;

  assign ea_raw = req_base_i + req_offset_i;
  assign accept = req_valid_i && (state_q == S_IDLE);
  assign tmo    = (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign lane   = ea_q[LW-1:0];

  // Low-address mask covering the natural alignment of the requested size.
  always_comb begin
    unique case (req_size_i)
      2'b00:   amask = ADDR_W'(0);
      2'b01:   amask = ADDR_W'(1);
      2'b10:   amask = ADDR_W'(3);
      default: amask = ADDR_W'(7);
    endcase
  end

`ifdef LSU_MISALIGN_CHK_EN
  logic misalign;
  assign misalign = (ea_raw & amask) != '0;
`endif

  // Control state: FSM, watchdog counter and the held response fields.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Payload capture on acceptance.
  // NOTE: payload registers are deliberately not reset; they are only
  // observed on the bus while a request is in flight, after being loaded.
  always_ff @(posedge clk) begin
    if (accept) begin
`ifdef LSU_MISALIGN_CHK_EN
      ea_q <= ea_raw;
`else
      ea_q <= ea_raw & ~amask;
`endif
      size_q  <= req_size_i;
      we_q    <= req_we_i;
      uns_q   <= req_unsigned_i;
      wdata_q <= req_wdata_i;
    end
  end

  // Next-state logic and response capture.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          cnt_d   = '0;
          state_d = S_REQ;
`ifdef LSU_MISALIGN_CHK_EN
          if (misalign) begin
            state_d = S_DONE;
            rdata_d = '0;
            err_d   = 1'b0;
          end
`endif
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (tmo) begin
          state_d = S_DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (mem_req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rsp_valid_i) begin
          state_d = S_DONE;
          err_d   = mem_rsp_err_i;
          rdata_d = (we_q || mem_rsp_err_i) ? '0 : load_ext;
        end else if (tmo) begin
          state_d = S_DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef LSU_MISALIGN_CHK_EN
  // Misalignment flag: DONE is entered straight from IDLE only for a
  // trapped misaligned access; it holds until the next completion.
  logic mis_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (state_d == S_DONE && state_q != S_DONE) begin
      mis_q <= (state_q == S_IDLE);
    end
  end
  assign rsp_misalign_o = mis_q;
`else
  assign rsp_misalign_o = 1'b0;
`endif

  // Byte mask of the access size before lane shifting.
  always_comb begin
    unique case (size_q)
      2'b00:   smask = 8'h01;
      2'b01:   smask = 8'h03;
      2'b10:   smask = 8'h0F;
      default: smask = 8'hFF;
    endcase
  end

  // Load extraction: move the addressed lane to bit 0, then extend.
  assign shifted = mem_rdata_i >> {lane, 3'b000};

  // Sign- or zero-extend from the access size.
  always_comb begin
    load_ext = shifted;
    unique case (size_q)
      2'b00:   load_ext = uns_q ? DATA_W'(shifted[7:0])
                                : DATA_W'($signed(shifted[7:0]));
      2'b01:   load_ext = uns_q ? DATA_W'(shifted[15:0])
                                : DATA_W'($signed(shifted[15:0]));
      2'b10:   load_ext = uns_q ? DATA_W'(shifted[31:0])
                                : DATA_W'($signed(shifted[31:0]));
      default: load_ext = shifted;
    endcase
  end

  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_addr_o      = {ea_q[ADDR_W-1:LW], LW'(0)};
  assign mem_we_o        = we_q;
  assign mem_wstrb_o     = we_q ? (NB'(smask) << lane) : '0;
  assign mem_wdata_o     = wdata_q << {lane, 3'b000};

  assign rsp_valid_o = (state_q == S_DONE);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // Handshake and hold outputs are suppressed while reset is applied.
  assign req_ready_o = !rst && (state_q == S_IDLE);
  assign busy_o      = !rst && ((req_valid_i && state_q == S_IDLE) ||
                                state_q == S_REQ || state_q == S_WAIT);

endmodule

// File: tb/tb_ysyx_23060072_lsu_pipe.sv
// Directed testbench for ysyx_23060072_lsu_pipe (DATA_W=32, TIMEOUT_CYC=8).
// Honors LSU_MISALIGN_CHK_EN to pick the expected misaligned-access behavior.
module tb_ysyx_23060072_lsu_pipe;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_base_i;
  logic [31:0] req_offset_i;
  logic [31:0] req_wdata_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rsp_err_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_misalign_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_23060072_lsu_pipe #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_base_i(req_base_i),
    .req_offset_i(req_offset_i), .req_wdata_i(req_wdata_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i),
    .mem_rsp_err_i(mem_rsp_err_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_misalign_o(rsp_misalign_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current cycle; the caller steps to accept it.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] wdata);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_base_i     = base;
    req_offset_i   = off;
    req_wdata_i    = wdata;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_base_i = '0; req_offset_i = '0; req_wdata_i = '0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = '0; mem_rsp_err_i = 1'b0;
    #2;
    // Reset state, with req_valid_i high to show busy_o is still held low.
    check("rst_mem_req_valid", {31'b0, mem_req_valid_o}, 32'd0);
    check("rst_rsp_valid",     {31'b0, rsp_valid_o}, 32'd0);
    check("rst_rsp_rdata",     rsp_rdata_o, 32'd0);
    check("rst_rsp_err",       {31'b0, rsp_err_o}, 32'd0);
    check("rst_misalign",      {31'b0, rsp_misalign_o}, 32'd0);
    check("rst_busy",          {31'b0, busy_o}, 32'd0);
    req_valid_i = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check("post_rst_ready", {31'b0, req_ready_o}, 32'd1);
    check("post_rst_busy",  {31'b0, busy_o}, 32'd0);

    // lb from 0x1000+3, data 0x80FFFFFF -> 0xFFFFFF80 at cycle 3.
    issue(1'b0, 2'b00, 1'b0, 32'h1000, 32'd3, 32'd0);
    check("lb_c0_ready", {31'b0, req_ready_o}, 32'd1);
    check("lb_c0_busy",  {31'b0, busy_o}, 32'd1);
    step(); req_valid_i = 1'b0;
    check("lb_c1_mvalid", {31'b0, mem_req_valid_o}, 32'd1);
    check("lb_c1_addr",   mem_addr_o, 32'h1000);
    check("lb_c1_we",     {31'b0, mem_we_o}, 32'd0);
    check("lb_c1_wstrb",  {28'b0, mem_wstrb_o}, 32'h0);
    check("lb_c1_ready",  {31'b0, req_ready_o}, 32'd0);
    mem_req_ready_i = 1'b1;
    step(); mem_req_ready_i = 1'b0;
    check("lb_c2_mvalid", {31'b0, mem_req_valid_o}, 32'd0);
    check("lb_c2_rvalid", {31'b0, rsp_valid_o}, 32'd0);
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h80FF_FFFF;
    step(); mem_rsp_valid_i = 1'b0;
    check("lb_c3_rvalid", {31'b0, rsp_valid_o}, 32'd1);
    check("lb_c3_rdata",  rsp_rdata_o, 32'hFFFF_FF80);
    check("lb_c3_err",    {31'b0, rsp_err_o}, 32'd0);
    check("lb_c3_busy",   {31'b0, busy_o}, 32'd0);
    step();
    check("lb_c4_rvalid", {31'b0, rsp_valid_o}, 32'd0);
    check("lb_c4_hold",   rsp_rdata_o, 32'hFFFF_FF80);
    check("lb_c4_ready",  {31'b0, req_ready_o}, 32'd1);

    // sh 0xABCD to 0x2002.
    issue(1'b1, 2'b01, 1'b0, 32'h2000, 32'd2, 32'h0000_ABCD);
    step(); req_valid_i = 1'b0;
    check("sh_addr",  mem_addr_o, 32'h2000);
    check("sh_we",    {31'b0, mem_we_o}, 32'd1);
    check("sh_wstrb", {28'b0, mem_wstrb_o}, 32'hC);
    check("sh_wdata", mem_wdata_o, 32'hABCD_0000);
    mem_req_ready_i = 1'b1;
    step(); mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    step(); mem_rsp_valid_i = 1'b0;
    check("sh_rvalid", {31'b0, rsp_valid_o}, 32'd1);
    check("sh_rdata",  rsp_rdata_o, 32'd0);
    step();
    check("sh_rvalid_once", {31'b0, rsp_valid_o}, 32'd0);

    // lhu from 0x5002, data 0x80017FFF -> 0x00008001.
    issue(1'b0, 2'b01, 1'b1, 32'h5000, 32'd2, 32'd0);
    step(); req_valid_i = 1'b0;
    check("lhu_addr", mem_addr_o, 32'h5000);
    mem_req_ready_i = 1'b1;
    step(); mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h8001_7FFF;
    step(); mem_rsp_valid_i = 1'b0;
    check("lhu_rdata", rsp_rdata_o, 32'h0000_8001);
    step();

    // lbu with bus error -> err=1, rdata=0, held afterwards.
    issue(1'b0, 2'b00, 1'b1, 32'h6000, 32'd1, 32'd0);
    step(); req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    step(); mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_err_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    step(); mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0;
    check("err_rvalid", {31'b0, rsp_valid_o}, 32'd1);
    check("err_flag",   {31'b0, rsp_err_o}, 32'd1);
    check("err_rdata",  rsp_rdata_o, 32'd0);
    step();
    check("err_hold", {31'b0, rsp_err_o}, 32'd1);

    // lw 0x3004 with mem_req_ready_i low for 5 cycles.
    issue(1'b0, 2'b10, 1'b0, 32'h3000, 32'd4, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(); req_valid_i = 1'b0;
      check("stall_mvalid", {31'b0, mem_req_valid_o}, 32'd1);
      check("stall_addr",   mem_addr_o, 32'h3004);
      check("stall_ready",  {31'b0, req_ready_o}, 32'd0);
    end
    step();
    check("stall_busy", {31'b0, busy_o}, 32'd1);
    mem_req_ready_i = 1'b1;
    step(); mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    step(); mem_rsp_valid_i = 1'b0;
    check("stall_rvalid", {31'b0, rsp_valid_o}, 32'd1);
    check("stall_rdata",  rsp_rdata_o, 32'h1234_5678);
    check("stall_err",    {31'b0, rsp_err_o}, 32'd0);
    step();

    // Timeout: 8 cycles in REQ+WAIT with no response, then a late response.
    issue(1'b0, 2'b10, 1'b0, 32'h4000, 32'd0, 32'd0);
    step(); req_valid_i = 1'b0;       // REQ, 1st cycle
    mem_req_ready_i = 1'b1;
    step(); mem_req_ready_i = 1'b0;   // WAIT, 2nd cycle
    for (int i = 0; i < 6; i++) begin // cycles 3..8
      step();
      check("tmo_pending_rvalid", {31'b0, rsp_valid_o}, 32'd0);
      check("tmo_pending_busy",   {31'b0, busy_o}, 32'd1);
    end
    step();
    check("tmo_rvalid", {31'b0, rsp_valid_o}, 32'd1);
    check("tmo_err",    {31'b0, rsp_err_o}, 32'd1);
    check("tmo_rdata",  rsp_rdata_o, 32'd0);
    check("tmo_mvalid", {31'b0, mem_req_valid_o}, 32'd0);
    step(); step();
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    step(); mem_rsp_valid_i = 1'b0;
    check("late_rvalid", {31'b0, rsp_valid_o}, 32'd0);
    check("late_err",    {31'b0, rsp_err_o}, 32'd1);
    check("late_rdata",  rsp_rdata_o, 32'd0);
    check("late_ready",  {31'b0, req_ready_o}, 32'd1);

    // lw at 0x1001.
    issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'd1, 32'd0);
    step(); req_valid_i = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
    check("mis_mvalid",   {31'b0, mem_req_valid_o}, 32'd0);
    check("mis_rvalid",   {31'b0, rsp_valid_o}, 32'd1);
    check("mis_flag",     {31'b0, rsp_misalign_o}, 32'd1);
    check("mis_rdata",    rsp_rdata_o, 32'd0);
    check("mis_err",      {31'b0, rsp_err_o}, 32'd0);
    step();
    check("mis_rvalid_off", {31'b0, rsp_valid_o}, 32'd0);
    check("mis_hold",       {31'b0, rsp_misalign_o}, 32'd1);
    check("mis_ready",      {31'b0, req_ready_o}, 32'd1);
`else
    check("mis_mvalid", {31'b0, mem_req_valid_o}, 32'd1);
    check("mis_addr",   mem_addr_o, 32'h1000);
    mem_req_ready_i = 1'b1;
    step(); mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'hCAFE_BABE;
    step(); mem_rsp_valid_i = 1'b0;
    check("mis_rvalid", {31'b0, rsp_valid_o}, 32'd1);
    check("mis_rdata",  rsp_rdata_o, 32'hCAFE_BABE);
    check("mis_flag",   {31'b0, rsp_misalign_o}, 32'd0);
    step();
`endif

    // Reset asserted during WAIT aborts the access.
    issue(1'b0, 2'b10, 1'b0, 32'h7000, 32'd0, 32'd0);
    step(); req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    step(); mem_req_ready_i = 1'b0;
    check("rstw_busy_before", {31'b0, busy_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_busy",    {31'b0, busy_o}, 32'd0);
    check("rstw_rvalid",  {31'b0, rsp_valid_o}, 32'd0);
    check("rstw_mvalid",  {31'b0, mem_req_valid_o}, 32'd0);
    check("rstw_err",     {31'b0, rsp_err_o}, 32'd0);
    check("rstw_rdata",   rsp_rdata_o, 32'd0);
    check("rstw_mis",     {31'b0, rsp_misalign_o}, 32'd0);
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h1111_1111;
    step();
    check("rstw_rvalid_hold", {31'b0, rsp_valid_o}, 32'd0);
    mem_rsp_valid_i = 1'b0;
    rst = 1'b0;
    step();
    check("rstw_after_rvalid", {31'b0, rsp_valid_o}, 32'd0);
    check("rstw_after_ready",  {31'b0, req_ready_o}, 32'd1);
    check("rstw_after_busy",   {31'b0, busy_o}, 32'd0);
    step();
    check("rstw_after2_rvalid", {31'b0, rsp_valid_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ysyx_23060072_lsu_pipe.md
YSYX_23060072_LSU_PIPE -- requirements
Module: ysyx_23060072_lsu_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, bus data width; legal values 32 or 64; NB = DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 256, maximum number of cycles spent in REQ+WAIT.
REQ-004 SHALL have ports, in this order:
- clk  in  1  the single clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  access request.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64).
- req_unsigned_i  in  1  1 = zero-extend load data, 0 = sign-extend.
- req_base_i  in  ADDR_W  base operand.
- req_offset_i  in  ADDR_W  offset operand.
- req_wdata_i  in  DATA_W  store data, right-aligned.
- mem_req_valid_o  out  1  bus request.
- mem_req_ready_i  in  1  bus accepts request.
- mem_addr_o  out  ADDR_W  NB-aligned bus address.
- mem_we_o  out  1  bus write.
- mem_wstrb_o  out  NB  byte strobes.
- mem_wdata_o  out  DATA_W  lane-shifted write data.
- mem_rsp_valid_i  in  1  bus response.
- mem_rdata_i  in  DATA_W  bus read data.
- mem_rsp_err_i  in  1  bus error, qualified by mem_rsp_valid_i.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  DATA_W  extended load result.
- rsp_err_o  out  1  bus error or timeout.
- rsp_misalign_o  out  1  misaligned access.
- busy_o  out  1  pipeline hold request.

Function
REQ-005 SHALL compute the effective address EA = req_base_i + req_offset_i, modulo 2^ADDR_W, and latch EA, size, we, unsigned and wdata on acceptance.
REQ-006 SHALL implement FSM states IDLE, REQ, WAIT, DONE; req_ready_o = (state==IDLE).
REQ-007 SHALL transition IDLE->REQ on req_valid_i&&req_ready_o; REQ->WAIT on mem_req_ready_i; WAIT->DONE on mem_rsp_valid_i; DONE->IDLE unconditionally.
REQ-008 SHALL hold mem_req_valid_o high and all mem_* request fields stable in REQ until mem_req_ready_i.
REQ-009 SHALL drive mem_addr_o = EA with its low log2(NB) bits cleared; lane offset L = EA[log2(NB)-1:0].
REQ-010 SHALL drive mem_wstrb_o = size mask (0x1/0x3/0xF/0xFF) << L, truncated to NB bits, and mem_wdata_o = req_wdata_i << 8*L; for loads, mem_wstrb_o = 0.
REQ-011 SHALL, on the load response, shift mem_rdata_i right by 8*L, then sign- or zero-extend from the access size into rsp_rdata_o; for stores, rsp_rdata_o = 0.
REQ-012 SHALL pulse rsp_valid_o for exactly one cycle in DONE; rsp_rdata_o, rsp_err_o and rsp_misalign_o SHALL hold until the next completion.
REQ-013 SHALL give a minimum latency of 3 cycles from acceptance to rsp_valid_o (accept in cycle 0, mem_req_ready_i in cycle 1, mem_rsp_valid_i in cycle 2, rsp_valid_o in cycle 3).
REQ-014 SHALL count cycles in REQ+WAIT; on reaching TIMEOUT_CYC it SHALL go to DONE with rsp_err_o=1 and rsp_rdata_o=0, and SHALL drop mem_req_valid_o.
REQ-015 SHALL ignore mem_rsp_valid_i outside WAIT, including late responses after a timeout.
REQ-016 SHALL set rsp_err_o = mem_rsp_err_i on the response; an erroring load SHALL return rsp_rdata_o = 0.
REQ-017 SHALL assert busy_o when (req_valid_i && state==IDLE) || state!=IDLE, excluding DONE.

Reset
REQ-018 SHALL, while rst is high, asynchronously force state IDLE, timeout counter 0, mem_req_valid_o 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0, rsp_misalign_o 0, and busy_o 0; req_ready_o SHALL be 1 after rst deasserts.
REQ-019 SHALL, when reset occurs mid-access, abort the access with no rsp_valid_o.

Configuration
REQ-020 SHALL, with LSU_MISALIGN_CHK_EN defined, detect misaligned accesses (half with EA[0]!=0, word with EA[1:0]!=0, dword with EA[2:0]!=0) and, for them, go IDLE->DONE with no bus request, rsp_misalign_o=1 and rsp_rdata_o=0.
REQ-021 SHALL, without LSU_MISALIGN_CHK_EN, tie rsp_misalign_o to 0 and clear EA bits below the size alignment before use.

Verification
REQ-022 SHALL cover: DATA_W=32, lb from base 0x1000 with offset 3, mem_rdata_i=0x80FFFFFF -> mem_addr_o=0x1000, rsp_rdata_o=0xFFFFFF80 at cycle 3.
REQ-023 SHALL cover: sh of wdata 0xABCD to EA 0x2002 -> mem_wstrb_o=0xC, mem_wdata_o=0xABCD0000, rsp_valid_o once, rsp_rdata_o=0.
REQ-024 SHALL cover: mem_req_ready_i held low 5 cycles -> mem_req_valid_o and mem_addr_o stable for 5 cycles, req_ready_o=0 throughout.
REQ-025 SHALL cover: TIMEOUT_CYC=8 with no response -> rsp_err_o=1 after 8 cycles in REQ+WAIT; a response arriving 2 cycles later is ignored.
REQ-026 SHALL cover: LSU_MISALIGN_CHK_EN defined, lw at 0x1001 -> no mem_req_valid_o, rsp_misalign_o=1; rst asserted during WAIT -> no rsp_valid_o and state IDLE.
